// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the two-port SDRAM arbiter.
//   SDRAM_ADDR_WIDTH / SDRAM_DATA_WIDTH / SDRAM_MASK_WIDTH : default widths
//   arb_state_t : arbiter FSM state encoding (IDLE, ISSUE, WAIT_DONE, RESPOND)
//   sdram_req_t : one request record (we, addr, data, mask) at default widths
// ---------------------------------------------------------------------------
package sdram_pkg;

  localparam int SDRAM_ADDR_WIDTH = 23;
  localparam int SDRAM_DATA_WIDTH = 32;
  localparam int SDRAM_MASK_WIDTH = SDRAM_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                        we;
    logic [SDRAM_ADDR_WIDTH-1:0] addr;
    logic [SDRAM_DATA_WIDTH-1:0] data;
    logic [SDRAM_MASK_WIDTH-1:0] mask;
  } sdram_req_t;

endpackage

// File: rtl/sdram_arb_select.sv
// ---------------------------------------------------------------------------
// sdram_arb_select
// Combinational winner selection between two requesters plus the
// last-granted pointer that makes ties alternate.
//   clk, rst_n : clock and asynchronous active-low reset
//   req0, req1 : live request lines
//   grant      : high in the cycle the arbiter accepts the current winner
//   any_req    : at least one request is present
//   winner     : 0 = port0, 1 = port1 (valid while any_req = 1)
// Configuration macro: SDRAM_ARB_FIXED_PRIO_EN -- when defined port0 always
// wins a tie and no pointer register exists.
// ---------------------------------------------------------------------------
module sdram_arb_select
  import sdram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant,
  output logic any_req,
  output logic winner
);

  assign any_req = req0 | req1;

`ifdef SDRAM_ARB_FIXED_PRIO_EN

  // Port0 wins whenever it is requesting; clock, reset and grant are not
  // needed because there is no state to keep.
  logic unused_inputs;
  assign unused_inputs = clk ^ rst_n ^ grant;

  assign winner = ~req0;

`else

  // Pointer to the port granted last; it starts at port1 so that port0
  // takes the first tie after reset.
  logic last_q;

  // On a tie the port not granted last wins, otherwise the lone requester.
  assign winner = (req0 & req1) ? ~last_q : ~req0;

  // The pointer only moves when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= winner;
    end
  end

`endif

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Two-port arbiter in front of the SoC side of sdram_controller. One command
// is in flight at a time: a winner is chosen in IDLE, its command is held on
// the controller interface until the controller goes busy, read data is
// captured when the controller signals ready, and the winner gets a single
// cycle done pulse once the controller is idle again.
// Ports:
//   clk, reset_n_port            : clock, asynchronous active-low reset
//   pN_req/pN_we                 : request (held until pN_done), 1 = write
//   pN_addr/pN_wr_data/pN_wr_mask: request payload
//   pN_done/pN_rd_data           : completion pulse, last read data of port N
//   ctl_addr/ctl_wr_data/ctl_wr_mask/ctl_wr_en/ctl_rd_en : command out
//   ctl_busy/ctl_ready/ctl_rd_data : controller status and read return
// Configuration macro: SDRAM_ARB_FIXED_PRIO_EN (fixed port0 priority on ties
// instead of round-robin; handled inside sdram_arb_select).
// ---------------------------------------------------------------------------
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SDRAM_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n_port,

  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wr_data,
  input  logic [DATA_WIDTH/8-1:0] p0_wr_mask,
  output logic                    p0_done,
  output logic [DATA_WIDTH-1:0]   p0_rd_data,

  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wr_data,
  input  logic [DATA_WIDTH/8-1:0] p1_wr_mask,
  output logic                    p1_done,
  output logic [DATA_WIDTH-1:0]   p1_rd_data,

  output logic [ADDR_WIDTH-1:0]   ctl_addr,
  output logic [DATA_WIDTH-1:0]   ctl_wr_data,
  output logic [DATA_WIDTH/8-1:0] ctl_wr_mask,
  output logic                    ctl_wr_en,
  output logic                    ctl_rd_en,
  input  logic                    ctl_busy,
  input  logic                    ctl_ready,
  input  logic [DATA_WIDTH-1:0]   ctl_rd_data
);

  arb_state_t state_q, state_d;
  logic       grant;
  logic       any_req;
  logic       sel_winner;
  logic       win_q;
  logic       cmd_we_q;

  sdram_arb_select u_select (
    .clk     (clk),
    .rst_n   (reset_n_port),
    .req0    (p0_req),
    .req1    (p1_req),
    .grant   (grant),
    .any_req (any_req),
    .winner  (sel_winner)
  );

  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants are only taken in IDLE, so a port whose done is pulsing in
  // RESPOND cannot be re-granted in that same cycle.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ctl_busy && any_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ctl_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!ctl_busy) begin
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command registers are loaded only on a grant, so the controller sees a
  // stable address/data/mask from ISSUE entry until RESPOND exits.
  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      win_q       <= 1'b0;
      cmd_we_q    <= 1'b0;
      ctl_addr    <= '0;
      ctl_wr_data <= '0;
      ctl_wr_mask <= '0;
    end else if (grant) begin
      win_q       <= sel_winner;
      cmd_we_q    <= sel_winner ? p1_we      : p0_we;
      ctl_addr    <= sel_winner ? p1_addr    : p0_addr;
      ctl_wr_data <= sel_winner ? p1_wr_data : p0_wr_data;
      ctl_wr_mask <= sel_winner ? p1_wr_mask : p0_wr_mask;
    end
  end

  // Read data lands in the winner's register only; each register keeps its
  // value until that port's next read completes.
  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      p0_rd_data <= '0;
      p1_rd_data <= '0;
    end else if (state_q == WAIT_DONE && ctl_ready && !cmd_we_q) begin
      if (win_q) begin
        p1_rd_data <= ctl_rd_data;
      end else begin
        p0_rd_data <= ctl_rd_data;
      end
    end
  end

  // Enables and done pulses decode the registered state, so reset forces
  // them low immediately and the two enables are mutually exclusive.
  assign ctl_wr_en = (state_q == ISSUE) &  cmd_we_q;
  assign ctl_rd_en = (state_q == ISSUE) & ~cmd_we_q;
  assign p0_done   = (state_q == RESPOND) & ~win_q;
  assign p1_done   = (state_q == RESPOND) &  win_q;

endmodule
